handshake_rr_merge: RTL and testbench



---
 rtl/handshake_rr_merge_pkg.sv | 16 +
 rtl/handshake_rr_merge_if.sv | 29 ++
 rtl/handshake_rr_merge_rr_arbiter.sv | 35 +++
 rtl/handshake_rr_merge.sv | 79 +++++++
 tb/tb_handshake_rr_merge.sv | 111 +++++++++++
 5 files changed

// File: rtl/handshake_rr_merge_pkg.sv
// handshake_merge_pkg: shared constants, payload type and index helpers for the round-robin merge
package handshake_merge_pkg;
  localparam int WIDTH_DEF = 5;
  localparam int N_DEF = 3;
  localparam int DEPTH_DEF = 2;
  localparam int SW_DEF = $clog2(N_DEF);
  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [SW_DEF-1:0]    src;
  } payload_t;
  // explicit wrap so non-power-of-two moduli behave
  function automatic int wrap_inc(input int v, input int m);
    return (v + 1 >= m) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/handshake_rr_merge_if.sv
// handshake_rr_merge_if: bundle of the N source channels and the single merged output channel
interface handshake_rr_merge_if
  import handshake_merge_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(DEPTH + 1);
  logic [N-1:0]            src_valid;
  logic [N-1:0]            src_ready;
  logic [N-1:0][WIDTH-1:0] src_a;
  logic [N-1:0][WIDTH-1:0] src_b;
  logic                    dst_valid;
  logic                    dst_ready;
  logic [WIDTH-1:0]        dst_in1;
  logic [WIDTH-1:0]        dst_in2;
  logic [SW-1:0]           dst_src;
  logic [CW-1:0]           count;
  modport slave (
    input  src_valid, src_a, src_b, dst_ready,
    output src_ready, dst_valid, dst_in1, dst_in2, dst_src, count
  );
  modport master (
    output src_valid, src_a, src_b, dst_ready,
    input  src_ready, dst_valid, dst_in1, dst_in2, dst_src, count
  );
endinterface

// File: rtl/handshake_rr_merge_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting at a held pointer that advances past each accepted winner
module rr_arbiter
  import handshake_merge_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx
);
  logic [SW-1:0] ptr;
  logic          found;
  // first requester at or after ptr, wrapping modulo N
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = SW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end
  // pointer moves just past the winner only when its beat is actually taken
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (adv) ptr <= SW'(wrap_inc(int'(idx), N));
  end
endmodule

// File: rtl/handshake_rr_merge.sv
// handshake_rr_merge: round-robin merge of N operand-pair sources into a small FIFO with a registered head
module handshake_rr_merge
  import handshake_merge_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic CLK,
  input logic RESET,
  handshake_rr_merge_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SW-1:0]    src;
  } entry_t;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_data;
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [AW-1:0] rd_inc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          valid_q;
  logic [N-1:0]  grant;
  logic [SW-1:0] gidx;
  logic          not_full;
  logic          push;
  logic          pop;
  rr_arbiter #(.N(N)) u_arb (
    .clk  (CLK),
    .rst  (RESET),
    .req  (bus.src_valid),
    .adv  (push),
    .grant(grant),
    .idx  (gidx)
  );
  assign not_full = count < CW'(DEPTH);
  assign bus.src_ready = grant & {N{not_full}};
  assign push = |grant && not_full;
  assign pop = valid_q && bus.dst_ready;
  assign wr_data = {bus.src_a[gidx], bus.src_b[gidx], gidx};
  assign rd_inc = AW'(wrap_inc(int'(rd), DEPTH));
  assign count_n = count + CW'(push) - CW'(pop);
  assign bus.dst_valid = valid_q;
  assign bus.dst_in1 = head.a;
  assign bus.dst_in2 = head.b;
  assign bus.dst_src = head.src;
  assign bus.count = count;
  // FIFO storage, indices and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr] <= wr_data;
        wr <= AW'(wrap_inc(int'(wr), DEPTH));
      end
      if (pop) rd <= rd_inc;
      count <= count_n;
      valid_q <= count_n != '0;
    end
  end
  // head copy kept in flops so dst_* never pass through the read mux; it only moves on pop or fill-from-empty
  always_ff @(posedge CLK) begin
    if (RESET) head <= '0;
    else if (push && (count == '0 || (pop && count == CW'(1)))) head <= wr_data;
    else if (pop && count > CW'(1)) head <= mem[rd_inc];
  end
endmodule

// File: tb/tb_handshake_rr_merge.sv
// tb_handshake_rr_merge: directed vector table plus reset sequences for the round-robin merge
module tb_handshake_rr_merge;
  import handshake_merge_pkg::*;
  typedef struct {
    logic [2:0]      sv;
    logic [2:0][4:0] a;
    logic [2:0][4:0] b;
    logic            dr;
    logic [2:0]      er;
    logic            ev;
    logic [4:0]      ea;
    logic [4:0]      eb;
    logic [1:0]      es;
    logic [1:0]      ec;
  } vec_t;
  localparam logic [2:0][4:0] RA = {5'd3, 5'd2, 5'd1};
  localparam logic [2:0][4:0] RB = {5'd11, 5'd10, 5'd9};
  localparam logic [2:0][4:0] Z = '0;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int total = 0;
  int bad = 0;
  vec_t vq[$];
  handshake_rr_merge_if bus ();
  handshake_rr_merge dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step%0d: got %0d want %0d", nm, id, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] sv, input logic [2:0][4:0] a, input logic [2:0][4:0] b, input logic dr);
    bus.src_valid = sv;
    bus.src_a = a;
    bus.src_b = b;
    bus.dst_ready = dr;
  endtask
  task automatic chk_out(input int id, input logic ev, input logic [4:0] ea, input logic [4:0] eb, input logic [1:0] es, input logic [1:0] ec);
    chk("dst_valid", id, 8'(bus.dst_valid), 8'(ev));
    chk("dst_in1", id, 8'(bus.dst_in1), 8'(ea));
    chk("dst_in2", id, 8'(bus.dst_in2), 8'(eb));
    chk("dst_src", id, 8'(bus.dst_src), 8'(es));
    chk("count", id, 8'(bus.count), 8'(ec));
  endtask
  initial begin
    payload_t p;
    // round robin: all valid, a=i+1, b=i+9
    vq.push_back('{3'b111, RA, RB, 1'b1, 3'b001, 1'b1, 5'd1, 5'd9, 2'd0, 2'd1});
    vq.push_back('{3'b111, RA, RB, 1'b1, 3'b010, 1'b1, 5'd2, 5'd10, 2'd1, 2'd1});
    vq.push_back('{3'b111, RA, RB, 1'b1, 3'b100, 1'b1, 5'd3, 5'd11, 2'd2, 2'd1});
    vq.push_back('{3'b111, RA, RB, 1'b1, 3'b001, 1'b1, 5'd1, 5'd9, 2'd0, 2'd1});
    vq.push_back('{3'b111, RA, RB, 1'b1, 3'b010, 1'b1, 5'd2, 5'd10, 2'd1, 2'd1});
    vq.push_back('{3'b111, RA, RB, 1'b1, 3'b100, 1'b1, 5'd3, 5'd11, 2'd2, 2'd1});
    vq.push_back('{3'b000, Z, Z, 1'b1, 3'b000, 1'b0, 5'd3, 5'd11, 2'd2, 2'd0});
    // backpressure from source 1, fill to full, then drain in order
    vq.push_back('{3'b010, {5'd0, 5'd7, 5'd0}, {5'd0, 5'd3, 5'd0}, 1'b0, 3'b010, 1'b1, 5'd7, 5'd3, 2'd1, 2'd1});
    vq.push_back('{3'b010, {5'd0, 5'd8, 5'd0}, {5'd0, 5'd4, 5'd0}, 1'b0, 3'b010, 1'b1, 5'd7, 5'd3, 2'd1, 2'd2});
    vq.push_back('{3'b010, {5'd0, 5'd9, 5'd0}, {5'd0, 5'd5, 5'd0}, 1'b0, 3'b000, 1'b1, 5'd7, 5'd3, 2'd1, 2'd2});
    vq.push_back('{3'b010, {5'd0, 5'd9, 5'd0}, {5'd0, 5'd5, 5'd0}, 1'b1, 3'b000, 1'b1, 5'd8, 5'd4, 2'd1, 2'd1});
    vq.push_back('{3'b000, Z, Z, 1'b1, 3'b000, 1'b0, 5'd8, 5'd4, 2'd1, 2'd0});
    // pointer hold: only source 2, then sources 0 and 2 with ptr wrapped to 0
    vq.push_back('{3'b100, {5'd5, 5'd0, 5'd0}, {5'd6, 5'd0, 5'd0}, 1'b1, 3'b100, 1'b1, 5'd5, 5'd6, 2'd2, 2'd1});
    vq.push_back('{3'b101, {5'd4, 5'd0, 5'd1}, {5'd4, 5'd0, 5'd2}, 1'b1, 3'b001, 1'b1, 5'd1, 5'd2, 2'd0, 2'd1});
    vq.push_back('{3'b000, Z, Z, 1'b1, 3'b000, 1'b0, 5'd1, 5'd2, 2'd0, 2'd0});
    drive(3'b111, RA, RB, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK);
      #1 chk_out(100 + c, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0);
    end
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      if (i != 0) @(negedge CLK);
      drive(vq[i].sv, vq[i].a, vq[i].b, vq[i].dr);
      #1 chk("src_ready", i, 8'(bus.src_ready), 8'(vq[i].er));
      @(posedge CLK);
      #1 chk_out(i, vq[i].ev, vq[i].ea, vq[i].eb, vq[i].es, vq[i].ec);
    end
    // mid-stream reset with two entries queued
    @(negedge CLK);
    drive(3'b001, {5'd0, 5'd0, 5'd3}, {5'd0, 5'd0, 5'd4}, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    drive(3'b001, {5'd0, 5'd0, 5'd6}, {5'd0, 5'd0, 5'd7}, 1'b0);
    @(posedge CLK);
    #1 chk_out(200, 1'b1, 5'd3, 5'd4, 2'd0, 2'd2);
    @(negedge CLK);
    RESET = 1'b1;
    bus.dst_ready = 1'b1;
    @(posedge CLK);
    #1 chk_out(201, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0);
    @(negedge CLK);
    RESET = 1'b0;
    drive(3'b000, Z, Z, 1'b1);
    #1 chk("src_ready", 202, 8'(bus.src_ready), 8'd0);
    @(posedge CLK);
    #1 chk_out(203, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0);
    @(negedge CLK);
    drive(3'b110, {5'd2, 5'd12, 5'd0}, {5'd9, 5'd13, 5'd0}, 1'b0);
    #1 chk("src_ready", 204, 8'(bus.src_ready), 8'b010);
    @(posedge CLK);
    #1;
    p = {bus.dst_in1, bus.dst_in2, bus.dst_src};
    chk("payload", 205, 8'(p.a), 8'd12);
    chk("payload_src", 205, 8'(p.src), 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
